mc_main_control: RTL and testbench

//  Multicycle main control FSM; drives datapath strobes and the 3-bit ALUOp consumed by ula_control.

---
 rtl/mc_main_control.sv | 198 +++++++++++++++++++
 tb/tb_mc_main_control.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute and drives datapath strobes + ALUOp.
// Optional feature macro: CTRL_TRAP_EN (illegal opcode traps until reset instead of acting as NOP).
module mc_main_control #(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zero_ext,
    output logic [1:0] pc_source,
    output logic [2:0] ALUOp,
    output logic       mem_timeout,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StIExec    = 4'd10,
        StIWb      = 4'd11,
        StTrap     = 4'd12
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpSltiu = 6'b001011;

    state_e     r_state;
    state_e     w_next;
    logic [7:0] r_wait;
    logic       w_mem_state;
    logic       w_timeout;

    assign w_mem_state = (r_state == StFetch) || (r_state == StMemRead) ||
                         (r_state == StMemWrite);
    // Abort fires on the MEM_WAIT_MAX-th stall cycle; a ready in that cycle takes priority.
    assign w_timeout = (MEM_WAIT_MAX != 0) && w_mem_state && !mem_ready &&
                       (({24'd0, r_wait} + 32'd1) == MEM_WAIT_MAX);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StFetch:    if (mem_ready) w_next = StDecode;
            StDecode: begin
                unique case (opcode)
                    OpLw, OpSw:     w_next = StMemAddr;
                    OpRType:        w_next = StRExec;
                    OpBeq, OpBne:   w_next = StBranch;
                    OpJ:            w_next = StJump;
                    OpAddi, OpAndi, OpOri, OpXori, OpSlti, OpSltiu: w_next = StIExec;
`ifdef CTRL_TRAP_EN
                    default:        w_next = StTrap;
`else
                    default:        w_next = StFetch;
`endif
                endcase
            end
            StMemAddr:  w_next = (opcode == OpLw) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready) w_next = StMemWb;
            StMemWrite: if (mem_ready) w_next = StFetch;
            StRExec:    w_next = StRWb;
            StIExec:    w_next = StIWb;
            StTrap:     w_next = StTrap;
            default:    w_next = StFetch;
        endcase
        if (w_timeout) w_next = StFetch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFetch;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_mem_state && !mem_ready && !w_timeout && (w_next == r_state)) begin
                if (r_wait != 8'hFF) r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        zero_ext      = 1'b0;
        pc_source     = 2'b00;
        ALUOp         = 3'b000;
        trap          = 1'b0;
        mem_timeout   = w_timeout && !rst;
        state         = rst ? 4'd0 : r_state;
        if (!rst) begin
            unique case (r_state)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StDecode:   alu_src_b = 2'b11;
                StMemAddr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StMemRead: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StMemWrite: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                StRExec: begin
                    alu_src_a = 1'b1;
                    ALUOp     = 3'b010;
                end
                StRWb: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                StBranch: begin
                    alu_src_a     = 1'b1;
                    ALUOp         = 3'b001;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    branch_ne     = (opcode == OpBne);
                end
                StJump: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                StIExec: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    unique case (opcode)
                        OpAndi:  begin ALUOp = 3'b011; zero_ext = 1'b1; end
                        OpOri:   begin ALUOp = 3'b100; zero_ext = 1'b1; end
                        OpXori:  begin ALUOp = 3'b101; zero_ext = 1'b1; end
                        OpSlti:  ALUOp = 3'b110;
                        OpSltiu: ALUOp = 3'b111;
                        default: ALUOp = 3'b000;
                    endcase
                end
                StIWb:      reg_write = 1'b1;
`ifdef CTRL_TRAP_EN
                StTrap:     trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: directed table, hand sequences, and randomized run against a
// behavioural model for two instances (MEM_WAIT_MAX = 0 and 4) sharing the same inputs.
module tb_mc_main_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] pc_source;
        logic [2:0] aluop;
        logic       mem_timeout;
        logic       trap;
        logic [3:0] state;
    } ctrl_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic [2:0] alu;
        logic       rw;
        logic       mr;
        logic       zx;
        logic       bne;
        logic       m2r;
    } vec_t;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100;
    localparam logic [5:0] ORI = 6'b001101, XORI = 6'b001110, SLTI = 6'b001010;
    localparam logic [5:0] SLTIU = 6'b001011, ILL = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    ctrl_t      act_a, act_b, last_a, last_b;
    int         checks = 0;
    int         failures = 0;
    int         m_state[2];
    int         m_wait[2];
    int         wait_max[2] = '{0, 4};
    vec_t       tbl[$];

    always #5 clk = ~clk;

    mc_main_control #(.MEM_WAIT_MAX(0)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(act_a.pc_write), .pc_write_cond(act_a.pc_write_cond),
        .branch_ne(act_a.branch_ne), .i_or_d(act_a.i_or_d), .mem_read(act_a.mem_read),
        .mem_write(act_a.mem_write), .ir_write(act_a.ir_write), .mem_to_reg(act_a.mem_to_reg),
        .reg_dst(act_a.reg_dst), .reg_write(act_a.reg_write), .alu_src_a(act_a.alu_src_a),
        .alu_src_b(act_a.alu_src_b), .zero_ext(act_a.zero_ext), .pc_source(act_a.pc_source),
        .ALUOp(act_a.aluop), .mem_timeout(act_a.mem_timeout), .trap(act_a.trap),
        .state(act_a.state)
    );

    mc_main_control #(.MEM_WAIT_MAX(4)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(act_b.pc_write), .pc_write_cond(act_b.pc_write_cond),
        .branch_ne(act_b.branch_ne), .i_or_d(act_b.i_or_d), .mem_read(act_b.mem_read),
        .mem_write(act_b.mem_write), .ir_write(act_b.ir_write), .mem_to_reg(act_b.mem_to_reg),
        .reg_dst(act_b.reg_dst), .reg_write(act_b.reg_write), .alu_src_a(act_b.alu_src_a),
        .alu_src_b(act_b.alu_src_b), .zero_ext(act_b.zero_ext), .pc_source(act_b.pc_source),
        .ALUOp(act_b.aluop), .mem_timeout(act_b.mem_timeout), .trap(act_b.trap),
        .state(act_b.state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {R, LW, SW, BEQ, BNE, J, ADDI, ANDI, ORI, XORI, SLTI, SLTIU};
    endfunction

    // A memory abort happens when this stall would be the wait_max-th in a row.
    function automatic bit model_abort(input int k, input logic rdy);
        bit in_mem = (m_state[k] == 0) || (m_state[k] == 3) || (m_state[k] == 5);
        return (wait_max[k] != 0) && in_mem && !rdy && (m_wait[k] + 1 == wait_max[k]);
    endfunction

    function automatic ctrl_t model_out(input int k, input logic r, input logic [5:0] op,
                                        input logic rdy);
        ctrl_t o = '0;
        if (r) return o;
        o.state = 4'(m_state[k]);
        o.mem_timeout = model_abort(k, rdy);
        case (m_state[k])
            0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            1: o.alu_src_b = 2'b11;
            2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3: begin o.mem_read = 1; o.i_or_d = 1; end
            4: begin o.reg_write = 1; o.mem_to_reg = 1; end
            5: begin o.mem_write = 1; o.i_or_d = 1; end
            6: begin o.alu_src_a = 1; o.aluop = 3'b010; end
            7: begin o.reg_write = 1; o.reg_dst = 1; end
            8: begin
                o.alu_src_a = 1; o.aluop = 3'b001; o.pc_write_cond = 1; o.pc_source = 2'b01;
                o.branch_ne = (op == BNE);
            end
            9: begin o.pc_write = 1; o.pc_source = 2'b10; end
            10: begin
                o.alu_src_a = 1; o.alu_src_b = 2'b10;
                o.zero_ext = (op == ANDI) || (op == ORI) || (op == XORI);
                o.aluop = (op == ANDI) ? 3'd3 : (op == ORI) ? 3'd4 : (op == XORI) ? 3'd5 :
                          (op == SLTI) ? 3'd6 : (op == SLTIU) ? 3'd7 : 3'd0;
            end
            11: o.reg_write = 1;
            12: o.trap = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic model_step(input int k, input logic r, input logic [5:0] op,
                              input logic rdy);
        int  nxt;
        bit  abort = model_abort(k, rdy);
        bit  in_mem = (m_state[k] == 0) || (m_state[k] == 3) || (m_state[k] == 5);
        if (r) begin
            m_state[k] = 0;
            m_wait[k] = 0;
            return;
        end
        case (m_state[k])
            0: nxt = rdy ? 1 : 0;
            1: begin
                if (op == LW || op == SW) nxt = 2;
                else if (op == R) nxt = 6;
                else if (op == BEQ || op == BNE) nxt = 8;
                else if (op == J) nxt = 9;
                else if (legal(op)) nxt = 10;
`ifdef CTRL_TRAP_EN
                else nxt = 12;
`else
                else nxt = 0;
`endif
            end
            2: nxt = (op == LW) ? 3 : 5;
            3: nxt = rdy ? 4 : 3;
            5: nxt = rdy ? 0 : 5;
            6: nxt = 7;
            10: nxt = 11;
            12: nxt = 12;
            default: nxt = 0;
        endcase
        if (abort) nxt = 0;
        m_wait[k] = (in_mem && !rdy && !abort && nxt == m_state[k]) ? m_wait[k] + 1 : 0;
        m_state[k] = nxt;
    endtask

    // One clock: drive at the falling edge, compare both instances to the model, advance the model.
    task automatic cycle(input logic r, input logic [5:0] op, input logic rdy);
        ctrl_t exp_a, exp_b;
        @(negedge clk);
        rst = r;
        opcode = op;
        mem_ready = rdy;
        #1;
        exp_a = model_out(0, r, op, rdy);
        exp_b = model_out(1, r, op, rdy);
        last_a = act_a;
        last_b = act_b;
        check("model_a", 32'(act_a), 32'(exp_a));
        check("model_b", 32'(act_b), 32'(exp_b));
        model_step(0, r, op, rdy);
        model_step(1, r, op, rdy);
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic rdy, input int st,
                       input int alu, input bit rw, input bit mr, input bit zx, input bit bne,
                       input bit m2r);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.st = 4'(st); v.alu = 3'(alu);
        v.rw = rw; v.mr = mr; v.zx = zx; v.bne = bne; v.m2r = m2r;
        tbl.push_back(v);
    endtask

    initial begin
        logic [5:0] rop;
        logic [5:0] ops[12] = '{R, LW, SW, BEQ, BNE, J, ADDI, ANDI, ORI, XORI, SLTI, SLTIU};
        m_state = '{0, 0};
        m_wait = '{0, 0};

        //  rst op     rdy st alu rw mr zx bne m2r
        add(1, R,     1,  0, 0,  0, 0, 0, 0,  0);
        add(0, R,     1,  0, 0,  0, 1, 0, 0,  0);
        add(0, R,     1,  1, 0,  0, 0, 0, 0,  0);
        add(0, R,     1,  6, 2,  0, 0, 0, 0,  0);
        add(0, R,     1,  7, 0,  1, 0, 0, 0,  0);
        add(0, LW,    1,  0, 0,  0, 1, 0, 0,  0);
        add(0, LW,    1,  1, 0,  0, 0, 0, 0,  0);
        add(0, LW,    1,  2, 0,  0, 0, 0, 0,  0);
        add(0, LW,    0,  3, 0,  0, 1, 0, 0,  0);
        add(0, LW,    0,  3, 0,  0, 1, 0, 0,  0);
        add(0, LW,    0,  3, 0,  0, 1, 0, 0,  0);
        add(0, LW,    1,  3, 0,  0, 1, 0, 0,  0);
        add(0, LW,    1,  4, 0,  1, 0, 0, 0,  1);
        add(0, ANDI,  1,  0, 0,  0, 1, 0, 0,  0);
        add(0, ANDI,  1,  1, 0,  0, 0, 0, 0,  0);
        add(0, ANDI,  1, 10, 3,  0, 0, 1, 0,  0);
        add(0, ANDI,  1, 11, 0,  1, 0, 0, 0,  0);
        add(0, BNE,   1,  0, 0,  0, 1, 0, 0,  0);
        add(0, BNE,   1,  1, 0,  0, 0, 0, 0,  0);
        add(0, BNE,   1,  8, 1,  0, 0, 0, 1,  0);
        add(0, SLTIU, 1,  0, 0,  0, 1, 0, 0,  0);
        add(0, SLTIU, 1,  1, 0,  0, 0, 0, 0,  0);
        add(0, SLTIU, 1, 10, 7,  0, 0, 0, 0,  0);
        add(0, SLTIU, 1, 11, 0,  1, 0, 0, 0,  0);
        add(0, J,     0,  0, 0,  0, 1, 0, 0,  0);
        add(0, J,     1,  0, 0,  0, 1, 0, 0,  0);
        add(0, J,     1,  1, 0,  0, 0, 0, 0,  0);
        add(0, J,     1,  9, 0,  0, 0, 0, 0,  0);
        add(0, J,     1,  0, 0,  0, 1, 0, 0,  0);

        cycle(1, R, 1);
        check("reset_all_zero", 32'(last_a), 32'd0);
        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].op, tbl[i].rdy);
            check($sformatf("vec%0d", i),
                  {20'd0, last_a.state, last_a.aluop, last_a.reg_write, last_a.mem_read,
                   last_a.zero_ext, last_a.branch_ne, last_a.mem_to_reg},
                  {20'd0, tbl[i].st, tbl[i].alu, tbl[i].rw, tbl[i].mr, tbl[i].zx,
                   tbl[i].bne, tbl[i].m2r});
        end

        // Store with memory never ready: instance with MEM_WAIT_MAX=4 aborts on the 4th stall.
        cycle(1, SW, 1);
        cycle(0, SW, 1);
        cycle(0, SW, 1);
        cycle(0, SW, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, SW, 0);
            check($sformatf("sw_wait%0d", i),
                  {29'd0, last_b.mem_write, last_b.mem_timeout, last_b.pc_write},
                  {29'd0, 1'b1, (i == 3), 1'b0});
        end
        cycle(0, SW, 0);
        check("sw_abort_to_fetch", 32'(last_b.state), 32'd0);
        check("sw_no_abort_a", 32'(last_a.state), 32'd5);

        // Illegal opcode handling.
        cycle(1, ILL, 1);
        cycle(0, ILL, 1);
        cycle(0, ILL, 1);
        check("ill_decode", 32'(last_a.state), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, ILL, 1);
`ifdef CTRL_TRAP_EN
            check("ill_trap", {27'd0, last_a.trap, last_a.state}, {27'd0, 1'b1, 4'd12});
`else
            check("ill_nop", {27'd0, last_a.trap, last_a.state},
                  {27'd0, 1'b0, (i == 1) ? 4'd1 : 4'd0});
`endif
        end
        cycle(1, R, 1);
        check("ill_reset_clears", 32'(last_a), 32'd0);

        // Randomized run: opcode only changes while both instances sit in FETCH.
        rop = R;
        for (int c = 0; c < 2000; c++) begin
            logic r = ($urandom_range(0, 79) == 0);
            logic rdy = ($urandom_range(0, 3) != 0);
            if (m_state[0] == 0 && m_state[1] == 0)
                rop = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            cycle(r, rop, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
